// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and entry type for the instruction fetch front-end.
package inst_fetch_unit_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetchEntry_t;

  // Fetch addresses are always word aligned; low bits of a target are ignored.
  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, inst} pairs; flush takes priority over push.
module fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  fetchEntry_t       pushData,
  input  logic              pop,
  input  logic              flush,
  output fetchEntry_t       headData,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);

  fetchEntry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]        wrPtr, rdPtr;
  logic                    doPush, doPop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign doPop  = pop && !empty && !flush;
  // A full FIFO can still take a push when the head leaves the same cycle.
  assign doPush = push && !flush && (!full || doPop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem   <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (doPop) rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign headData = mem[rdPtr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: credit-limited sequential requests, in-order response capture,
// redirect flush with drop counting for in-flight responses, halt support.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 3
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        fetch_idle
);

  logic [31:0]      fetchPc, respPc;
  logic [CNT_W-1:0] outstanding, dropCnt, fifoCount;
  logic [CNT_W:0]   liveCnt;
  logic             fifoEmpty, fifoFull;
  logic             creditOk, reqFire, respDrop, respPush, fifoPop;
  fetchEntry_t      headEntry, pushEntry;

  // Every live request owns a FIFO slot, so responses never need backpressure.
  assign liveCnt  = {1'b0, outstanding} - {1'b0, dropCnt} + {1'b0, fifoCount};
  assign creditOk = liveCnt < (CNT_W+1)'(FIFO_DEPTH);

  assign imem_req_valid = reset && !redirect_valid && !halt && creditOk;
  assign imem_req_addr  = fetchPc;
  assign reqFire        = imem_req_valid && imem_req_ready;

  assign respDrop  = imem_resp_valid && (dropCnt != '0);
  assign respPush  = imem_resp_valid && (dropCnt == '0) && !redirect_valid;
  assign pushEntry = '{pc: respPc, inst: imem_resp_data};

  assign inst_valid = !fifoEmpty && !redirect_valid;
  assign fifoPop    = inst_valid && inst_ready;
  assign inst_out   = headEntry.inst;
  assign inst_pc    = headEntry.pc;
  assign fetch_idle = reset && halt && (outstanding == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
    end else begin
      case ({reqFire, imem_resp_valid})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (redirect_valid) begin
        fetchPc <= alignPc(redirect_pc);
        respPc  <= alignPc(redirect_pc);
        // The response landing this cycle is already gone; drop the rest.
        dropCnt <= outstanding - CNT_W'(imem_resp_valid);
      end else begin
        if (reqFire)  fetchPc <= fetchPc + PC_INC;
        if (respDrop) dropCnt <= dropCnt - CNT_W'(1);
        if (respPush) respPc  <= respPc + PC_INC;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) uFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (respPush),
    .pushData (pushEntry),
    .pop      (fifoPop),
    .flush    (redirect_valid),
    .headData (headEntry),
    .count    (fifoCount),
    .empty    (fifoEmpty),
    .full     (fifoFull)
  );

  // Full is implied by the credit rule; kept on the FIFO for observability.
  logic unusedFull;
  assign unusedFull = fifoFull;

endmodule
